mem_stage_lsu: RTL and testbench

// - MEM-stage load/store unit; consumes the EX/MEM pipeline register outputs and drives the next stage.
// - Runs a req/ready handshake to data memory for each load or store, and stalls the front of the pipe until the access ends.
// - Hands a registered result bundle to the MEM/WB register; non-memory instructions pass through in 1 cycle.

---
 rtl/mem_stage_lsu.sv | 183 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: runs one data-memory access per load/store, stalls the
// front of the pipe while it waits, and registers the result bundle for MEM/WB.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] aluResultIN,
    input  logic [31:0] writeDataIN,
    input  logic [4:0]  rdAddrIN,
    input  logic [31:0] pcPlus4IN,
    input  logic        RegWriteIN,
    input  logic        MemWriteIN,
    input  logic [1:0]  ResultSrcIN,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] readDataOUT,
    output logic [31:0] aluResultOUT,
    output logic [4:0]  rdAddrOUT,
    output logic [31:0] pcPlus4OUT,
    output logic        RegWriteOUT,
    output logic [1:0]  ResultSrcOUT,
    output logic        err_misalign,
    output logic        err_timeout,
    output logic        state_dbg_o
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [4:0]  lat_rd_q, lat_rd_d;
    logic [31:0] lat_pc4_q, lat_pc4_d;
    logic        lat_rw_q, lat_rw_d;
    logic [1:0]  lat_rs_q, lat_rs_d;
    logic [31:0] out_rdata_q, out_rdata_d, out_alu_q, out_alu_d, out_pc4_q, out_pc4_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic        out_rw_q, out_rw_d;
    logic [1:0]  out_rs_q, out_rs_d;
    logic        mis_q, mis_d, tmo_q, tmo_d;

    logic memop, aligned, timeout_hit;

    // Handshake: dmem_req is held high with stable we/addr/wdata until the cycle in
    // which dmem_ready is seen (that cycle carries rdata) or the access times out.
    assign memop       = MemWriteIN | (ResultSrcIN == 2'b01);
    assign aligned     = (aluResultIN[1:0] == 2'b00);
    assign timeout_hit = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign stall       = ((state_q == S_IDLE) && memop && aligned) ||
                         ((state_q == S_WAIT) && !dmem_ready && !timeout_hit);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lat_rd_d    = lat_rd_q;
        lat_pc4_d   = lat_pc4_q;
        lat_rw_d    = lat_rw_q;
        lat_rs_d    = lat_rs_q;
        out_rdata_d = out_rdata_q;
        out_alu_d   = out_alu_q;
        out_rd_d    = out_rd_q;
        out_pc4_d   = out_pc4_q;
        out_rw_d    = out_rw_q;
        out_rs_d    = out_rs_q;
        mis_d       = 1'b0;
        tmo_d       = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (memop && aligned) begin
                    state_d     = S_WAIT;
                    cnt_d       = '0;
                    req_d       = 1'b1;
                    we_d        = MemWriteIN;
                    addr_d      = aluResultIN;
                    wdata_d     = writeDataIN;
                    lat_rd_d    = rdAddrIN;
                    lat_pc4_d   = pcPlus4IN;
                    lat_rw_d    = RegWriteIN;
                    lat_rs_d    = ResultSrcIN;
                    out_rdata_d = '0;
                    out_alu_d   = '0;
                    out_rd_d    = '0;
                    out_pc4_d   = '0;
                    out_rw_d    = 1'b0;
                    out_rs_d    = '0;
                end else begin
                    // Non-memory ops pass through; a misaligned access is squashed here.
                    out_rdata_d = '0;
                    out_alu_d   = aluResultIN;
                    out_rd_d    = rdAddrIN;
                    out_pc4_d   = pcPlus4IN;
                    out_rw_d    = RegWriteIN & ~memop;
                    out_rs_d    = ResultSrcIN;
                    mis_d       = memop;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (dmem_ready || timeout_hit) begin
                    state_d     = S_IDLE;
                    req_d       = 1'b0;
                    out_alu_d   = addr_q;
                    out_rd_d    = lat_rd_q;
                    out_pc4_d   = lat_pc4_q;
                    out_rs_d    = lat_rs_q;
                    out_rdata_d = (dmem_ready && !we_q) ? dmem_rdata : 32'h0;
                    out_rw_d    = dmem_ready && lat_rw_q && !we_q;
                    tmo_d       = tmo_q | ~dmem_ready;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lat_rd_q    <= '0;
            lat_pc4_q   <= '0;
            lat_rw_q    <= 1'b0;
            lat_rs_q    <= '0;
            out_rdata_q <= '0;
            out_alu_q   <= '0;
            out_rd_q    <= '0;
            out_pc4_q   <= '0;
            out_rw_q    <= 1'b0;
            out_rs_q    <= '0;
            mis_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lat_rd_q    <= lat_rd_d;
            lat_pc4_q   <= lat_pc4_d;
            lat_rw_q    <= lat_rw_d;
            lat_rs_q    <= lat_rs_d;
            out_rdata_q <= out_rdata_d;
            out_alu_q   <= out_alu_d;
            out_rd_q    <= out_rd_d;
            out_pc4_q   <= out_pc4_d;
            out_rw_q    <= out_rw_d;
            out_rs_q    <= out_rs_d;
            mis_q       <= mis_d;
            tmo_q       <= tmo_d;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign readDataOUT  = out_rdata_q;
    assign aluResultOUT = out_alu_q;
    assign rdAddrOUT    = out_rd_q;
    assign pcPlus4OUT   = out_pc4_q;
    assign RegWriteOUT  = out_rw_q;
    assign ResultSrcOUT = out_rs_q;
    assign err_misalign = mis_q;
    assign err_timeout  = tmo_q;
    assign state_dbg_o  = (state_q == S_WAIT);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a 4-cycle timeout so the abort path is reachable.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] aluResultIN, writeDataIN, pcPlus4IN;
    logic [4:0]  rdAddrIN;
    logic        RegWriteIN, MemWriteIN;
    logic [1:0]  ResultSrcIN;
    logic        dmem_req, dmem_we, dmem_ready, stall;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] readDataOUT, aluResultOUT, pcPlus4OUT;
    logic [4:0]  rdAddrOUT;
    logic        RegWriteOUT, err_misalign, err_timeout, state_dbg_o;
    logic [1:0]  ResultSrcOUT;

    int vec_cnt = 0;
    int err_cnt = 0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(4), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .aluResultIN(aluResultIN), .writeDataIN(writeDataIN), .rdAddrIN(rdAddrIN),
        .pcPlus4IN(pcPlus4IN), .RegWriteIN(RegWriteIN), .MemWriteIN(MemWriteIN),
        .ResultSrcIN(ResultSrcIN),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .stall(stall), .readDataOUT(readDataOUT), .aluResultOUT(aluResultOUT),
        .rdAddrOUT(rdAddrOUT), .pcPlus4OUT(pcPlus4OUT), .RegWriteOUT(RegWriteOUT),
        .ResultSrcOUT(ResultSrcOUT), .err_misalign(err_misalign), .err_timeout(err_timeout),
        .state_dbg_o(state_dbg_o)
    );

    always #5 clk = ~clk;

    task automatic set_inputs(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                              input logic [31:0] pc4, input logic rw, input logic mw, input logic [1:0] rs);
        aluResultIN = alu; writeDataIN = wd; rdAddrIN = rd;
        pcPlus4IN = pc4; RegWriteIN = rw; MemWriteIN = mw; ResultSrcIN = rs;
    endtask

    task automatic drive_nop();
        @(negedge clk);
        set_inputs(32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 2'b00);
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
    endtask

    // Called just after inputs are set at a negedge; answers the request in WAIT cycle k.
    task automatic run_access(input int k, input logic [31:0] rdata, output int stalls,
                              output logic req_seen, output logic we_seen,
                              output logic [31:0] addr_seen, output logic [31:0] wdata_seen);
        stalls = 0;
        #1 if (stall) stalls++;
        @(posedge clk); #1;
        req_seen = dmem_req; we_seen = dmem_we; addr_seen = dmem_addr; wdata_seen = dmem_wdata;
        for (int c = 1; c <= k; c++) begin
            @(negedge clk);
            dmem_ready = (c == k);
            dmem_rdata = (c == k) ? rdata : 32'h0;
            #1 if (stall) stalls++;
        end
        @(posedge clk); #1;
        dmem_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_inputs(32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 2'b00);
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        vec_cnt++; if (dmem_req !== 1'b0) begin err_cnt++; $display("FAIL reset_req: got %b want 0", dmem_req); end
        vec_cnt++; if (state_dbg_o !== 1'b0) begin err_cnt++; $display("FAIL reset_state: got %b want 0", state_dbg_o); end
        vec_cnt++; if (err_timeout !== 1'b0 || err_misalign !== 1'b0) begin err_cnt++; $display("FAIL reset_err: got %b%b want 00", err_timeout, err_misalign); end
        vec_cnt++; if ({readDataOUT, aluResultOUT, pcPlus4OUT} !== 96'h0) begin err_cnt++; $display("FAIL reset_bundle: got %h want 0", {readDataOUT, aluResultOUT, pcPlus4OUT}); end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_alu();
        @(negedge clk);
        set_inputs(32'h10, 32'h99, 5'd5, 32'h44, 1'b1, 1'b0, 2'b00);
        #1;
        vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL alu_stall: got %b want 0", stall); end
        @(posedge clk); #1;
        vec_cnt++; if (aluResultOUT !== 32'h10) begin err_cnt++; $display("FAIL alu_result: got %h want 10", aluResultOUT); end
        vec_cnt++; if (rdAddrOUT !== 5'd5 || RegWriteOUT !== 1'b1) begin err_cnt++; $display("FAIL alu_rd_rw: got %0d/%b want 5/1", rdAddrOUT, RegWriteOUT); end
        vec_cnt++; if (pcPlus4OUT !== 32'h44 || readDataOUT !== 32'h0) begin err_cnt++; $display("FAIL alu_pc_rdata: got %h/%h want 44/0", pcPlus4OUT, readDataOUT); end
        vec_cnt++; if (dmem_req !== 1'b0) begin err_cnt++; $display("FAIL alu_req: got %b want 0", dmem_req); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        set_inputs(32'h1234, 32'h0, 5'd9, 32'h80, 1'b1, 1'b0, 2'b10);
        @(negedge clk);
        vec_cnt++; if (aluResultOUT !== 32'h1234 || ResultSrcOUT !== 2'b10) begin err_cnt++; $display("FAIL b2b_first: got %h/%b want 1234/10", aluResultOUT, ResultSrcOUT); end
        set_inputs(32'h5678, 32'h0, 5'd3, 32'h84, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        vec_cnt++; if (aluResultOUT !== 32'h5678 || rdAddrOUT !== 5'd3 || RegWriteOUT !== 1'b0) begin err_cnt++; $display("FAIL b2b_second: got %h/%0d/%b want 5678/3/0", aluResultOUT, rdAddrOUT, RegWriteOUT); end
    endtask

    task automatic test_load();
        int stalls; logic rq, we; logic [31:0] ad, wd;
        @(negedge clk);
        set_inputs(32'h100, 32'h0, 5'd7, 32'h200, 1'b1, 1'b0, 2'b01);
        run_access(3, 32'hDEADBEEF, stalls, rq, we, ad, wd);
        vec_cnt++; if (rq !== 1'b1 || we !== 1'b0 || ad !== 32'h100) begin err_cnt++; $display("FAIL load_req: got %b/%b/%h want 1/0/100", rq, we, ad); end
        vec_cnt++; if (stalls != 3) begin err_cnt++; $display("FAIL load_stalls: got %0d want 3", stalls); end
        vec_cnt++; if (readDataOUT !== 32'hDEADBEEF || ResultSrcOUT !== 2'b01) begin err_cnt++; $display("FAIL load_data: got %h/%b want deadbeef/01", readDataOUT, ResultSrcOUT); end
        vec_cnt++; if (RegWriteOUT !== 1'b1 || rdAddrOUT !== 5'd7 || pcPlus4OUT !== 32'h200) begin err_cnt++; $display("FAIL load_bundle: got %b/%0d/%h want 1/7/200", RegWriteOUT, rdAddrOUT, pcPlus4OUT); end
        vec_cnt++; if (dmem_req !== 1'b0 || state_dbg_o !== 1'b0) begin err_cnt++; $display("FAIL load_done: got %b/%b want 0/0", dmem_req, state_dbg_o); end
        drive_nop();
    endtask

    task automatic test_store();
        int stalls; logic rq, we; logic [31:0] ad, wd;
        @(negedge clk);
        set_inputs(32'h104, 32'hCAFE, 5'd2, 32'h300, 1'b1, 1'b1, 2'b00);
        run_access(1, 32'h5555AAAA, stalls, rq, we, ad, wd);
        vec_cnt++; if (rq !== 1'b1 || we !== 1'b1 || ad !== 32'h104 || wd !== 32'hCAFE) begin err_cnt++; $display("FAIL store_req: got %b/%b/%h/%h want 1/1/104/cafe", rq, we, ad, wd); end
        vec_cnt++; if (stalls != 1) begin err_cnt++; $display("FAIL store_stalls: got %0d want 1", stalls); end
        vec_cnt++; if (RegWriteOUT !== 1'b0 || readDataOUT !== 32'h0) begin err_cnt++; $display("FAIL store_out: got %b/%h want 0/0", RegWriteOUT, readDataOUT); end
        drive_nop();
    endtask

    task automatic test_misalign();
        @(negedge clk);
        set_inputs(32'h102, 32'h0, 5'd4, 32'h400, 1'b1, 1'b0, 2'b01);
        #1;
        vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL mis_stall: got %b want 0", stall); end
        @(posedge clk); #1;
        vec_cnt++; if (dmem_req !== 1'b0 || err_misalign !== 1'b1) begin err_cnt++; $display("FAIL mis_pulse: got req %b err %b want 0/1", dmem_req, err_misalign); end
        vec_cnt++; if (RegWriteOUT !== 1'b0 || aluResultOUT !== 32'h102) begin err_cnt++; $display("FAIL mis_bundle: got %b/%h want 0/102", RegWriteOUT, aluResultOUT); end
        drive_nop();
        @(posedge clk); #1;
        vec_cnt++; if (err_misalign !== 1'b0) begin err_cnt++; $display("FAIL mis_clear: got %b want 0", err_misalign); end
    endtask

    task automatic test_ready_last();
        int stalls; logic rq, we; logic [31:0] ad, wd;
        @(negedge clk);
        set_inputs(32'h180, 32'h0, 5'd11, 32'h500, 1'b1, 1'b0, 2'b01);
        run_access(4, 32'h0BADF00D, stalls, rq, we, ad, wd);
        vec_cnt++; if (stalls != 4) begin err_cnt++; $display("FAIL late_stalls: got %0d want 4", stalls); end
        vec_cnt++; if (readDataOUT !== 32'h0BADF00D || RegWriteOUT !== 1'b1) begin err_cnt++; $display("FAIL late_data: got %h/%b want 0badf00d/1", readDataOUT, RegWriteOUT); end
        vec_cnt++; if (err_timeout !== 1'b0) begin err_cnt++; $display("FAIL late_no_tmo: got %b want 0", err_timeout); end
        drive_nop();
    endtask

    task automatic test_timeout();
        int stalls = 0;
        @(negedge clk);
        set_inputs(32'h200, 32'h0, 5'd12, 32'h600, 1'b1, 1'b0, 2'b01);
        #1 if (stall) stalls++;
        @(posedge clk); #1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); #1;
            if (stall) stalls++;
        end
        @(posedge clk); #1;
        vec_cnt++; if (stalls != 4) begin err_cnt++; $display("FAIL tmo_stalls: got %0d want 4", stalls); end
        vec_cnt++; if (err_timeout !== 1'b1 || dmem_req !== 1'b0 || state_dbg_o !== 1'b0) begin err_cnt++; $display("FAIL tmo_abort: got tmo %b req %b st %b want 1/0/0", err_timeout, dmem_req, state_dbg_o); end
        vec_cnt++; if (RegWriteOUT !== 1'b0 || rdAddrOUT !== 5'd12) begin err_cnt++; $display("FAIL tmo_bundle: got %b/%0d want 0/12", RegWriteOUT, rdAddrOUT); end
        @(negedge clk);
        set_inputs(32'h20, 32'h0, 5'd1, 32'h0, 1'b1, 1'b0, 2'b00);
        @(posedge clk); #1;
        vec_cnt++; if (err_timeout !== 1'b1 || aluResultOUT !== 32'h20) begin err_cnt++; $display("FAIL tmo_sticky: got %b/%h want 1/20", err_timeout, aluResultOUT); end
        drive_nop();
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        set_inputs(32'h300, 32'h0, 5'd6, 32'h700, 1'b1, 1'b0, 2'b01);
        @(posedge clk); #1;
        vec_cnt++; if (dmem_req !== 1'b1) begin err_cnt++; $display("FAIL rst_pre_req: got %b want 1", dmem_req); end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        vec_cnt++; if (dmem_req !== 1'b0 || state_dbg_o !== 1'b0 || err_timeout !== 1'b0) begin err_cnt++; $display("FAIL rst_mid: got req %b st %b tmo %b want 0/0/0", dmem_req, state_dbg_o, err_timeout); end
        vec_cnt++; if ({readDataOUT, aluResultOUT, pcPlus4OUT, rdAddrOUT, RegWriteOUT, ResultSrcOUT} !== 104'h0) begin err_cnt++; $display("FAIL rst_mid_bundle: got %h want 0", {readDataOUT, aluResultOUT, pcPlus4OUT}); end
        drive_nop();
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        vec_cnt++; if (dmem_req !== 1'b0 || state_dbg_o !== 1'b0) begin err_cnt++; $display("FAIL rst_after: got %b/%b want 0/0", dmem_req, state_dbg_o); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_store();
        test_misalign();
        test_ready_last();
        test_timeout();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
